mem_delay_injector: RTL and testbench

//  Multi-channel, parametrised successor to the single-request instruction delay stage.

---
 rtl/mem_delay_pkg.sv | 20 ++
 rtl/mem_delay_channel.sv | 106 ++++++++++
 rtl/mem_delay_injector.sv | 50 +++++
 tb/tb_mem_delay_injector.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_delay_pkg.sv
// Shared constants and entry bundle for the memory delay injector.
// Optional jitter via MEM_DELAY_JITTER_EN uses the LFSR constants below.
package mem_delay_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_PAYLOAD_W = 70;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_DELAY_W   = 6;
    localparam int DEF_JITTER_W  = 3;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [DEF_PAYLOAD_W-1:0] payload;
        logic [DEF_DELAY_W-1:0]   cnt;
    } entry_t;

endpackage

// File: rtl/mem_delay_channel.sv
// One delay channel: in-order FIFO whose entries count down independently.
// MEM_DELAY_JITTER_EN adds a per-channel LFSR that lengthens each delay.
module mem_delay_channel
    import mem_delay_pkg::*;
#(
    parameter int PayloadWidth = DEF_PAYLOAD_W,
    parameter int Depth        = DEF_DEPTH,
    parameter int DelayWidth   = DEF_DELAY_W,
    parameter int JitterWidth  = DEF_JITTER_W,
    parameter int ChIdx        = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DelayWidth-1:0]       cfg_delay_i,
    input  logic                        flush_i,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic [PayloadWidth-1:0]     payload_i,
    output logic                        req_o,
    input  logic                        gnt_i,
    output logic [PayloadWidth-1:0]     payload_o,
    output logic [$clog2(Depth):0]      pending_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PayloadWidth-1:0] payload;
        logic [DelayWidth-1:0]   cnt;
    } slot_t;

    slot_t           mem [Depth];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   pending;
    logic [DelayWidth-1:0] cnt_load;
    logic            push;
    logic            pop;

    assign gnt_o     = (pending != CW'(Depth));
    assign req_o     = (pending != '0) && (mem[rd_ptr].cnt == '0);
    assign payload_o = mem[rd_ptr].payload;
    assign pending_o = pending;

    assign push = req_i & gnt_o & ~flush_i;
    assign pop  = req_o & gnt_i & ~flush_i;

`ifdef MEM_DELAY_JITTER_EN
    localparam int SW = DelayWidth + 1;
    logic [15:0]   lfsr;
    logic [SW-1:0] sum;

    assign sum      = {1'b0, cfg_delay_i} + SW'(lfsr[JitterWidth-1:0]);
    assign cnt_load = sum[DelayWidth] ? '1 : sum[DelayWidth-1:0];

    // Advance the jitter source once per accepted request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr <= LFSR_SEED + 16'(ChIdx);
        end else if (push) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0);
        end
    end
`else
    logic unused_par;

    assign cnt_load   = cfg_delay_i;
    assign unused_par = ^{32'(JitterWidth), 32'(ChIdx)};
`endif

    // Load new entries, count every slot down toward zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (push && wr_ptr == AW'(i)) begin
                    mem[i] <= '{payload: payload_i, cnt: cnt_load};
                end else if (mem[i].cnt != '0) begin
                    mem[i].cnt <= mem[i].cnt - 1'b1;
                end
            end
        end
    end

    // Pointers and occupancy; flush wins over push and pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            pending <= pending + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/mem_delay_injector.sv
// Multi-channel request delay injector for latency-tolerance testing.
// Build with MEM_DELAY_JITTER_EN to add random extra delay per request.
module mem_delay_injector
    import mem_delay_pkg::*;
#(
    parameter int NumChannels  = DEF_NUM_CH,
    parameter int PayloadWidth = DEF_PAYLOAD_W,
    parameter int Depth        = DEF_DEPTH,
    parameter int DelayWidth   = DEF_DELAY_W,
    parameter int JitterWidth  = DEF_JITTER_W
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumChannels*DelayWidth-1:0]     cfg_delay_i,
    input  logic [NumChannels-1:0]                flush_i,
    input  logic [NumChannels-1:0]                req_i,
    output logic [NumChannels-1:0]                gnt_o,
    input  logic [NumChannels*PayloadWidth-1:0]   payload_i,
    output logic [NumChannels-1:0]                req_o,
    input  logic [NumChannels-1:0]                gnt_i,
    output logic [NumChannels*PayloadWidth-1:0]   payload_o,
    output logic [NumChannels*($clog2(Depth)+1)-1:0] pending_o
);

    localparam int CW = $clog2(Depth) + 1;

    // One independent channel per port slice
    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        mem_delay_channel #(
            .PayloadWidth (PayloadWidth),
            .Depth        (Depth),
            .DelayWidth   (DelayWidth),
            .JitterWidth  (JitterWidth),
            .ChIdx        (c)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .cfg_delay_i (cfg_delay_i[c*DelayWidth +: DelayWidth]),
            .flush_i     (flush_i[c]),
            .req_i       (req_i[c]),
            .gnt_o       (gnt_o[c]),
            .payload_i   (payload_i[c*PayloadWidth +: PayloadWidth]),
            .req_o       (req_o[c]),
            .gnt_i       (gnt_i[c]),
            .payload_o   (payload_o[c*PayloadWidth +: PayloadWidth]),
            .pending_o   (pending_o[c*CW +: CW])
        );
    end

endmodule

// File: tb/tb_mem_delay_injector.sv
// Scoreboard bench for mem_delay_injector.
// Model follows MEM_DELAY_JITTER_EN when the build defines it.
module tb_mem_delay_injector;

    localparam int NC = 2;
    localparam int PW = 70;
    localparam int DP = 4;
    localparam int DW = 6;
    localparam int JW = 3;
    localparam int CW = $clog2(DP) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC*DW-1:0] cfg_delay;
    logic [NC-1:0]    flush;
    logic [NC-1:0]    req_i;
    logic [NC-1:0]    gnt_o;
    logic [NC*PW-1:0] pl_i;
    logic [NC-1:0]    req_o;
    logic [NC-1:0]    gnt_i;
    logic [NC*PW-1:0] pl_o;
    logic [NC*CW-1:0] pend;

    always #5 clk = ~clk;

    mem_delay_injector #(
        .NumChannels  (NC),
        .PayloadWidth (PW),
        .Depth        (DP),
        .DelayWidth   (DW),
        .JitterWidth  (JW)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_delay_i (cfg_delay),
        .flush_i     (flush),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .payload_i   (pl_i),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .payload_o   (pl_o),
        .pending_o   (pend)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [PW-1:0] pl;
        int            rdy;
    } sb_t;

    sb_t         q [NC][$];
    logic [15:0] mlfsr [NC];
    int          mcyc = 0;

    // Reference: check outputs, then apply the coming edge to the model
    always @(negedge clk) begin
        bit er;
        bit full;
        int d;
        sb_t e;
        for (int c = 0; c < NC; c++) begin
            if (rst) begin
                q[c].delete();
                mlfsr[c] = 16'hACE1 + 16'(c);
            end else begin
                er   = (q[c].size() != 0) && (mcyc >= q[c][0].rdy);
                full = (q[c].size() == DP);
                chk($sformatf("req_o%0d", c), 128'(req_o[c]), 128'(er));
                chk($sformatf("gnt_o%0d", c), 128'(gnt_o[c]), 128'(!full));
                chk($sformatf("pend%0d", c), 128'(pend[c*CW +: CW]),
                    128'(q[c].size()));
                if (q[c].size() != 0) begin
                    chk($sformatf("pl_o%0d", c), 128'(pl_o[c*PW +: PW]),
                        128'(q[c][0].pl));
                end
                if (flush[c]) begin
                    q[c].delete();
                end else begin
                    if (er && gnt_i[c]) begin
                        void'(q[c].pop_front());
                    end
                    if (req_i[c] && !full) begin
                        d = int'(cfg_delay[c*DW +: DW]);
`ifdef MEM_DELAY_JITTER_EN
                        d = d + int'(mlfsr[c][JW-1:0]);
                        if (d > (1 << DW) - 1) d = (1 << DW) - 1;
                        mlfsr[c] = {1'b0, mlfsr[c][15:1]}
                                 ^ (mlfsr[c][0] ? 16'hB400 : 16'h0);
`endif
                        e.pl  = pl_i[c*PW +: PW];
                        e.rdy = mcyc + 1 + d;
                        q[c].push_back(e);
                    end
                end
            end
        end
        mcyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(int c, int d);
        cfg_delay[c*DW +: DW] = DW'(d);
    endtask

    task automatic push(int c, logic [PW-1:0] p);
        bit ok;
        int n;
        n = 0;
        req_i[c] = 1'b1;
        pl_i[c*PW +: PW] = p;
        do begin
            @(negedge clk);
            ok = gnt_o[c];
            tick();
            n++;
        end while (!ok && n < 50);
        req_i[c] = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_empty(int c);
        int n;
        n = 0;
        while (pend[c*CW +: CW] != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", 128'(pend[c*CW +: CW]), 0);
    endtask

    task automatic lat(int c, output int n);
        n = 0;
        while (!req_o[c] && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int n0;
        int n1;
        rst       = 1'b1;
        cfg_delay = '0;
        flush     = '0;
        req_i     = '0;
        gnt_i     = '0;
        pl_i      = '0;
        repeat (3) tick();
        chk("rst_req", 128'(req_o), 0);
        chk("rst_pend", 128'(pend), 0);
        chk("rst_gnt", 128'(gnt_o), 128'(2'b11));
        chk("rst_pl", 128'(pl_o), 0);
        rst = 1'b0;
        tick();

        // T1: single request, delay 3
        set_cfg(0, 3);
        gnt_i = 2'b11;
        push(0, 70'h1_1111_2222_3333_4444);
        lat(0, n);
        chk("t1_lat", 128'(n), 3);
        chk("t1_pl", 128'(pl_o[PW-1:0]), 128'(70'h1_1111_2222_3333_4444));
        tick();
        chk("t1_pulse", 128'(req_o[0]), 0);

        // T2: zero delay, back to back
        set_cfg(0, 0);
        push(0, 70'hA);
        push(0, 70'hB);
        push(0, 70'hC);
        wait_empty(0);

        // T3: fill channel 1 with grant held off
        set_cfg(1, 2);
        gnt_i[1] = 1'b0;
        for (int i = 0; i < 4; i++) push(1, 70'(32'h100 + i));
        chk("t3_gnt", 128'(gnt_o[1]), 0);
        chk("t3_pend", 128'(pend[2*CW-1:CW]), 4);
        req_i[1] = 1'b1;
        pl_i[2*PW-1:PW] = 70'h105;
        repeat (3) tick();
        chk("t3_hold", 128'(pend[2*CW-1:CW]), 4);
        gnt_i[1] = 1'b1;
        tick();
        chk("t3_pop1", 128'(pend[2*CW-1:CW]), 3);
        chk("t3_regnt", 128'(gnt_o[1]), 1);
        tick();
        req_i[1] = 1'b0;
        wait_empty(1);

        // T4: flush with entries queued
        set_cfg(0, 5);
        push(0, 70'hD0);
        push(0, 70'hD1);
        flush[0] = 1'b1;
        req_i[0] = 1'b1;
        pl_i[PW-1:0] = 70'hDEAD;
        tick();
        flush[0] = 1'b0;
        req_i[0] = 1'b0;
        chk("t4_pend", 128'(pend[CW-1:0]), 0);
        chk("t4_req", 128'(req_o[0]), 0);
        push(0, 70'hD2);
        lat(0, n);
        chk("t4_lat", 128'(n), 5);
        wait_empty(0);

        // T5: both channels at once, different delays
        set_cfg(0, 1);
        set_cfg(1, 6);
        req_i = 2'b11;
        pl_i  = {70'hE1, 70'hE0};
        tick();
        req_i = 2'b00;
        n0 = -1;
        n1 = -1;
        for (int i = 0; i < 20; i++) begin
            if (req_o[0] && n0 < 0) n0 = i;
            if (req_o[1] && n1 < 0) n1 = i;
            tick();
        end
        chk("t5_lat0", 128'(n0), 1);
        chk("t5_lat1", 128'(n1), 6);

        // T6: reset with entries queued
        set_cfg(0, 10);
        gnt_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) push(0, 70'(32'hF0 + i));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_pend", 128'(pend), 0);
        chk("t6_req", 128'(req_o), 0);
        tick();
        rst = 1'b0;
        tick();

        // Random traffic on both channels
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NC; c++) begin
                req_i[c] = 1'($urandom_range(0, 1));
                gnt_i[c] = ($urandom_range(0, 3) != 0);
                flush[c] = ($urandom_range(0, 40) == 0);
                pl_i[c*PW +: PW] = {6'($urandom), $urandom, $urandom};
                if ($urandom_range(0, 7) == 0) set_cfg(c, $urandom_range(0, 7));
            end
            tick();
        end
        req_i = '0;
        flush = '0;
        gnt_i = 2'b11;
        wait_empty(0);
        wait_empty(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
